// File: rtl/decoder_seq_amisha.sv
// decoder_seq_amisha
// N-to-2^N one-hot decoder with enable and a registered output, plus a small
// sequencer. It supports direct decode, auto-scan up or down with a
// programmable dwell, and a timed one-shot. The outputs depend only on
// registered state, so there is no combinational path from the inputs to y.
module decoder_seq_amisha #(
    parameter int N_AMISHA       = 2,
    parameter int DWELL_W_AMISHA = 4
) (
    input  logic                      clk_amisha,
    input  logic                      rst_n_amisha,
    input  logic                      en_amisha,
    input  logic                      load_amisha,
    input  logic [1:0]                mode_amisha,
    input  logic [N_AMISHA-1:0]       a_amisha,
    input  logic [DWELL_W_AMISHA-1:0] dwell_amisha,
    output logic [2**N_AMISHA-1:0]    y_amisha,
    output logic [N_AMISHA-1:0]       idx_amisha,
    output logic                      busy_amisha,
    output logic                      wrap_amisha
);

    localparam int OUT_W = 2**N_AMISHA;
    localparam logic [N_AMISHA-1:0] IDX_MAX  = '1;
    localparam logic [N_AMISHA-1:0] IDX_ZERO = '0;

    localparam logic [1:0] MODE_DIRECT    = 2'b00;
    localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
    localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
    localparam logic [1:0] MODE_ONESHOT   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_PULSE  = 2'd3
    } state_t;

    state_t                    state_reg,   state_next;
    logic [N_AMISHA-1:0]       idx_reg,     idx_next;
    logic [DWELL_W_AMISHA-1:0] cnt_reg,     cnt_next;
    logic [DWELL_W_AMISHA-1:0] dwell_q_reg, dwell_q_next;
    logic                      dir_q_reg,   dir_q_next;   // 0 = up, 1 = down
    logic                      wrap_reg,    wrap_next;

    // One-hot decode of the current index. It is gated by state further below.
    logic [OUT_W-1:0] onehot;

    // Dwell expiry shared by the SCAN and PULSE states.
    logic dwell_done;
    assign dwell_done = (cnt_reg == dwell_q_reg);

    // Next index of a scan step. Wrapping is modulo 2**N because the width is fixed.
    logic [N_AMISHA-1:0] idx_step;
    logic                step_wraps;
    assign idx_step   = dir_q_reg ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
    assign step_wraps = dir_q_reg ? (idx_reg == IDX_ZERO) : (idx_reg == IDX_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < OUT_W; gi++) begin : g_decode
            localparam logic [N_AMISHA-1:0] GI_IDX = N_AMISHA'(gi);
            assign onehot[gi] = (idx_reg == GI_IDX);
        end
    endgenerate

    // State and datapath registers. Reset aborts any operation immediately.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            state_reg   <= ST_IDLE;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            dwell_q_reg <= '0;
            dir_q_reg   <= 1'b0;
            wrap_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            dwell_q_reg <= dwell_q_next;
            dir_q_reg   <= dir_q_next;
            wrap_reg    <= wrap_next;
        end
    end

    // Next-state and datapath update. Priority is en=0, then load=1, then the state action.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        dwell_q_next = dwell_q_reg;
        dir_q_next   = dir_q_reg;
        wrap_next    = 1'b0;

        if (!en_amisha) begin
            // Disabled: drop to IDLE. The index and count hold so idx stays observable.
            state_next = ST_IDLE;
        end else if (load_amisha) begin
            // Start or restart from any state, including while busy.
            cnt_next = '0;
            idx_next = a_amisha;
            case (mode_amisha)
                MODE_DIRECT: begin
                    state_next = ST_DIRECT;
                end
                MODE_SCAN_UP, MODE_SCAN_DOWN: begin
                    state_next   = ST_SCAN;
                    dwell_q_next = dwell_amisha;
                    dir_q_next   = mode_amisha[1];
                end
                MODE_ONESHOT: begin
                    state_next   = ST_PULSE;
                    dwell_q_next = dwell_amisha;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_IDLE;
                end
                ST_DIRECT: begin
                    // The address is tracked every edge, so y follows a one cycle later.
                    idx_next = a_amisha;
                end
                ST_SCAN: begin
                    if (dwell_done) begin
                        cnt_next  = '0;
                        idx_next  = idx_step;
                        wrap_next = step_wraps;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                ST_PULSE: begin
                    if (dwell_done) begin
                        state_next = ST_IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs, decoded purely from registered state.
    always_comb begin
        y_amisha    = (state_reg != ST_IDLE) ? onehot : '0;
        idx_amisha  = idx_reg;
        busy_amisha = (state_reg == ST_SCAN) || (state_reg == ST_PULSE);
        wrap_amisha = wrap_reg;
    end

endmodule

// File: tb/tb_decoder_seq_amisha.sv
// Testbench for decoder_seq_amisha (N=2, DWELL_W=4).
// It applies a table of per-cycle vectors and compares against hand-computed
// expectations. Hand-written sequences cover async reset behaviour.
module tb_decoder_seq_amisha;

    logic       clk_amisha = 1'b0;
    logic       rst_n_amisha;
    logic       en_amisha;
    logic       load_amisha;
    logic [1:0] mode_amisha;
    logic [1:0] a_amisha;
    logic [3:0] dwell_amisha;
    logic [3:0] y_amisha;
    logic [1:0] idx_amisha;
    logic       busy_amisha;
    logic       wrap_amisha;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       load;
        logic [1:0] mode;
        logic [1:0] a;
        logic [3:0] dwell;
        logic [3:0] y;
        logic [1:0] idx;
        logic       busy;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    decoder_seq_amisha #(.N_AMISHA(2), .DWELL_W_AMISHA(4)) dut (
        .clk_amisha   (clk_amisha),
        .rst_n_amisha (rst_n_amisha),
        .en_amisha    (en_amisha),
        .load_amisha  (load_amisha),
        .mode_amisha  (mode_amisha),
        .a_amisha     (a_amisha),
        .dwell_amisha (dwell_amisha),
        .y_amisha     (y_amisha),
        .idx_amisha   (idx_amisha),
        .busy_amisha  (busy_amisha),
        .wrap_amisha  (wrap_amisha)
    );

    always #5 clk_amisha = ~clk_amisha;

    function automatic vec_t mk(input logic en, input logic load, input logic [1:0] mode,
                                input logic [1:0] a, input logic [3:0] dwell,
                                input logic [3:0] y, input logic [1:0] idx,
                                input logic busy, input logic wrap);
        vec_t v;
        v.en = en; v.load = load; v.mode = mode; v.a = a; v.dwell = dwell;
        v.y = y; v.idx = idx; v.busy = busy; v.wrap = wrap;
        return v;
    endfunction

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [3:0] y, input logic [1:0] idx,
                                 input logic busy, input logic wrap);
        check4({tag, " y"},    y_amisha,             y);
        check4({tag, " idx"},  {2'b00, idx_amisha},  {2'b00, idx});
        check4({tag, " busy"}, {3'b000, busy_amisha}, {3'b000, busy});
        check4({tag, " wrap"}, {3'b000, wrap_amisha}, {3'b000, wrap});
    endtask

    // Drive inputs just after an edge, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic en, input logic load, input logic [1:0] mode,
                        input logic [1:0] a, input logic [3:0] dwell);
        en_amisha = en; load_amisha = load; mode_amisha = mode;
        a_amisha = a; dwell_amisha = dwell;
        @(posedge clk_amisha);
        #1;
    endtask

    initial begin
        // en load mode a dwell | y idx busy wrap
        // Idle after reset
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd0, 4'b0000,2'd0,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd0, 4'b0000,2'd0,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd0, 4'b0000,2'd0,0,0));
        // DIRECT: a=10 then a=01, then a=11
        vecs.push_back(mk(1,1,2'b00,2'b10,4'd0, 4'b0100,2'd2,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b01,4'd0, 4'b0010,2'd1,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b01,4'd0, 4'b0010,2'd1,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd0, 4'b1000,2'd3,0,0));
        // SCAN_UP from 3, dwell=1; a changes are ignored
        vecs.push_back(mk(1,1,2'b01,2'b11,4'd1, 4'b1000,2'd3,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b1000,2'd3,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b0001,2'd0,1,1));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b0001,2'd0,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd7, 4'b0100,2'd2,1,0));
        // SCAN_DOWN from 0, dwell=0
        vecs.push_back(mk(1,1,2'b10,2'b00,4'd0, 4'b0001,2'd0,1,0));
        vecs.push_back(mk(1,0,2'b11,2'b10,4'd5, 4'b1000,2'd3,1,1));
        vecs.push_back(mk(1,0,2'b11,2'b10,4'd5, 4'b0100,2'd2,1,0));
        vecs.push_back(mk(1,0,2'b11,2'b10,4'd5, 4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b11,2'b10,4'd5, 4'b0001,2'd0,1,0));
        vecs.push_back(mk(1,0,2'b11,2'b10,4'd5, 4'b1000,2'd3,1,1));
        // en=0 beats load=1 mid-scan; idx holds
        vecs.push_back(mk(0,1,2'b00,2'b01,4'd0, 4'b0000,2'd3,0,0));
        vecs.push_back(mk(0,0,2'b00,2'b01,4'd0, 4'b0000,2'd3,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b01,4'd0, 4'b0000,2'd3,0,0));
        // ONESHOT a=01, dwell=2: three cycles high, then idle
        vecs.push_back(mk(1,1,2'b11,2'b01,4'd2, 4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd15,4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd15,4'b0010,2'd1,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd15,4'b0000,2'd1,0,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd15,4'b0000,2'd1,0,0));
        // Load during PULSE restarts with the new a; dwell=0 gives a 1-cycle pulse
        vecs.push_back(mk(1,1,2'b11,2'b10,4'd3, 4'b0100,2'd2,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b00,4'd0, 4'b0100,2'd2,1,0));
        vecs.push_back(mk(1,1,2'b11,2'b00,4'd0, 4'b0001,2'd0,1,0));
        vecs.push_back(mk(1,0,2'b00,2'b11,4'd0, 4'b0000,2'd0,0,0));

        // Reset state
        rst_n_amisha = 1'b0;
        en_amisha = 1'b0; load_amisha = 1'b0; mode_amisha = 2'b00;
        a_amisha = 2'b00; dwell_amisha = 4'd0;
        repeat (2) @(posedge clk_amisha);
        #1;
        check_outputs("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("reset: y=%b idx=%0d busy=%b wrap=%b", y_amisha, idx_amisha, busy_amisha, wrap_amisha);
        rst_n_amisha = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].load, vecs[i].mode, vecs[i].a, vecs[i].dwell);
            check_outputs($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].busy, vecs[i].wrap);
            $display("vec%0d: en=%b load=%b mode=%b a=%b dwell=%0d -> y=%b idx=%0d busy=%b wrap=%b",
                     i, vecs[i].en, vecs[i].load, vecs[i].mode, vecs[i].a, vecs[i].dwell,
                     y_amisha, idx_amisha, busy_amisha, wrap_amisha);
        end

        // Async reset mid-SCAN clears the outputs without waiting for a clock edge.
        step(1, 1, 2'b01, 2'b01, 4'd0);
        step(1, 0, 2'b01, 2'b01, 4'd0);
        check_outputs("scan_pre_rst", 4'b0100, 2'd2, 1'b1, 1'b0);
        #2;
        rst_n_amisha = 1'b0;
        #1;
        check_outputs("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("async_rst: y=%b idx=%0d busy=%b wrap=%b", y_amisha, idx_amisha, busy_amisha, wrap_amisha);
        @(posedge clk_amisha);
        #1;
        rst_n_amisha = 1'b1;
        step(1, 0, 2'b01, 2'b01, 4'd0);
        check_outputs("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        $display("post_rst_idle: y=%b idx=%0d busy=%b", y_amisha, idx_amisha, busy_amisha);

        // A scan with a long dwell holds for dwell+1 cycles, then steps up.
        step(1, 1, 2'b01, 2'b10, 4'd3);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 2'b00, 2'b00, 4'd0);
            check_outputs($sformatf("dwell3_hold%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        step(1, 0, 2'b00, 2'b00, 4'd0);
        check_outputs("dwell3_step", 4'b1000, 2'd3, 1'b1, 1'b0);
        $display("dwell3: y=%b idx=%0d busy=%b wrap=%b", y_amisha, idx_amisha, busy_amisha, wrap_amisha);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
